// File: rtl/extend.sv
// ---------------------------------------------------------------------------
// extend
//
// Registered immediate extender sitting between instruction decode and the
// ALU operand mux. Widens an IN_W-bit field to OUT_W bits, zero- or
// sign-extending it. The source is either the whole field or its low byte.
// The result appears one cycle after the input cycle, together with a valid
// flag.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   a          in   IN_W   source field
//   sext       in   1      1 = sign-extend, 0 = zero-extend
//   size       in   1      0 = source is a[IN_W-1:0], 1 = source is a[7:0]
//   in_valid   in   1      qualifies a / sext / size this cycle
//   b          out  OUT_W  extended result (registered)
//   out_valid  out  1      b holds a result captured from an in_valid cycle
//
// Handshake: in_valid is a plain qualifier with no back-pressure. Each cycle
// with in_valid=1 yields one result on b with out_valid=1 one cycle later.
// A cycle with in_valid=0 leaves b unchanged and clears out_valid.
//
// Parameter constraints: OUT_W > IN_W, and IN_W >= 8 so that byte mode has a
// full byte to take.
// ---------------------------------------------------------------------------
module extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  a,
    input  logic             sext,
    input  logic             size,
    input  logic             in_valid,
    output logic [OUT_W-1:0] b,
    output logic             out_valid
);

    // Low-bit mask covering the selected source width. Bits outside the mask
    // are fill bits.
    localparam logic [OUT_W-1:0] HALF_MASK = {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}};
    localparam logic [OUT_W-1:0] BYTE_MASK = {{(OUT_W-8){1'b0}}, 8'hFF};

    logic [OUT_W-1:0] low_mask;
    logic [OUT_W-1:0] src_wide;
    logic             sign_bit;
    logic             fill_bit;
    logic [OUT_W-1:0] b_d;
    logic [OUT_W-1:0] b_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        low_mask = HALF_MASK;
        sign_bit = a[IN_W-1];
        if (size) begin
            low_mask = BYTE_MASK;
            sign_bit = a[7];
        end

        // Zero-extend a, then drop the bits a byte-mode source ignores.
        src_wide = {{(OUT_W-IN_W){1'b0}}, a} & low_mask;
        fill_bit = sext & sign_bit;

        // Fill sets every bit above the source; the low bits pass through.
        b_d = fill_bit ? (src_wide | ~low_mask) : src_wide;

        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (in_valid) begin
                b_q <= b_d;
            end
        end
    end

    assign b         = b_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_extend.sv
// ---------------------------------------------------------------------------
// tb_extend
//
// Directed bench for extend: reset behaviour, half-word and byte extension,
// back-to-back issue, hold on idle cycles and reset in mid-stream.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_extend;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic        sext;
    logic        size;
    logic        in_valid;
    logic [31:0] b;
    logic        out_valid;

    int n_vec;
    int n_err;

    extend #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .sext      (sext),
        .size      (size),
        .in_valid  (in_valid),
        .b         (b),
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs on the falling edge, then wait until just
    // after the next rising edge so the registered outputs can be sampled.
    task automatic drive(input logic r, input logic v, input logic [15:0] av,
                         input logic sx, input logic sz);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av;
        sext     = sx;
        size     = sz;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       tag;
        logic [15:0] a;
        logic        sext;
        logic        size;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"zero_sx",      16'h0000, 1'b1, 1'b0, 32'h0000_0000});
        vecs.push_back('{"h8000_zx",     16'h8000, 1'b0, 1'b0, 32'h0000_8000});
        vecs.push_back('{"h8000_sx",     16'h8000, 1'b1, 1'b0, 32'hFFFF_8000});
        vecs.push_back('{"hFFFF_zx",     16'hFFFF, 1'b0, 1'b0, 32'h0000_FFFF});
        vecs.push_back('{"hFFFF_sx",     16'hFFFF, 1'b1, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{"byte_1280_sx", 16'h1280, 1'b1, 1'b1, 32'hFFFF_FF80});
        vecs.push_back('{"byte_1280_zx", 16'h1280, 1'b0, 1'b1, 32'h0000_0080});
        vecs.push_back('{"byte_FF7F_sx", 16'hFF7F, 1'b1, 1'b1, 32'h0000_007F});
        vecs.push_back('{"byte_FF7F_zx", 16'hFF7F, 1'b0, 1'b1, 32'h0000_007F});
        vecs.push_back('{"h7FFF_sx",     16'h7FFF, 1'b1, 1'b0, 32'h0000_7FFF});
        vecs.push_back('{"h8000_sx_b",   16'h8000, 1'b1, 1'b0, 32'hFFFF_8000});
    end

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        sext     = 1'b0;
        size     = 1'b0;

        // Reset has priority over a valid input on the same edge.
        drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("rst_b",     b,                 32'h0000_0000);
        check("rst_valid", {31'b0, out_valid}, 32'h0);

        // Idle cycle after reset: nothing becomes valid.
        drive(1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0);
        check("idle_b",     b,                 32'h0000_0000);
        check("idle_valid", {31'b0, out_valid}, 32'h0);

        // Back-to-back stream, one result per cycle with no bubbles.
        foreach (vecs[i]) begin
            drive(1'b0, 1'b1, vecs[i].a, vecs[i].sext, vecs[i].size);
            check(vecs[i].tag, b, vecs[i].exp);
            check({vecs[i].tag, "_valid"}, {31'b0, out_valid}, 32'h1);
        end

        // Hold: last result is FFFF8000; idle cycles with changing inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'(16'h1111 * (i + 1)), 1'(i), 1'(i >> 1));
            check("hold_b",     b,                 32'hFFFF_8000);
            check("hold_valid", {31'b0, out_valid}, 32'h0);
        end

        // Mid-stream reset discards the in-flight input.
        drive(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("pre_rst_b", b, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
        check("mid_rst_b",     b,                 32'h0000_0000);
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);

        // First valid input after reset appears one cycle later.
        drive(1'b0, 1'b1, 16'h00F0, 1'b1, 1'b1);
        check("post_rst_b",     b,                 32'hFFFF_FFF0);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("post_rst_hold_b",     b,                 32'hFFFF_FFF0);
        check("post_rst_hold_valid", {31'b0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
